// File: rtl/tx_channel_arbiter.sv
// Shares the serial memory TX channel between prefetcher (PF) and scheduler (SC) and
// routes RX events back to the requester that issued each outstanding read.
module tx_channel_arbiter #(
    parameter int unsigned IO_BITS         = 2,
    parameter int unsigned CMD_BITS        = 2,
    parameter int unsigned MAX_OUTSTANDING = 7,
    parameter int unsigned MAX_SC_STREAK   = 3,
    localparam int unsigned CntW           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pf_cmd_valid,
    input  logic [CMD_BITS-1:0] pf_cmd,
    input  logic [IO_BITS-1:0]  pf_data,
    input  logic                sc_cmd_valid,
    input  logic [CMD_BITS-1:0] sc_cmd,
    input  logic [IO_BITS-1:0]  sc_data,
    input  logic                sc_reply_wanted,
    input  logic                sc_reserve,
    output logic                tx_command_valid,
    output logic [CMD_BITS-1:0] tx_command,
    output logic [IO_BITS-1:0]  tx_data,
    input  logic [2:0]          tx_ev,
    input  logic                tx_active,
    output logic [2:0]          pf_tx_ev,
    output logic [2:0]          sc_tx_ev,
    input  logic [4:0]          rx_ev,
    output logic [4:0]          pf_rx_ev,
    output logic [4:0]          sc_rx_ev,
    output logic                sc_owner,
    output logic [CntW-1:0]     outstanding,
    output logic                full,
    output logic                empty,
    output logic                rx_orphan
);

    localparam int unsigned StrW = $clog2(MAX_SC_STREAK + 1);
    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [StrW-1:0] StreakMax = StrW'(MAX_SC_STREAK);
    localparam logic [PtrW-1:0] PtrLast   = PtrW'(MAX_OUTSTANDING - 1);

    logic                       choice;
    logic                       owner_q;
    logic                       owner_valid;
    logic [StrW-1:0]            streak_q, streak_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q;
    logic [PtrW-1:0]            rd_q, wr_q;
    logic [CntW-1:0]            count_q, count_d;
    logic                       started, push, pop, head;

    always_comb begin
        choice = 1'b0;
        if (sc_reserve) begin
            choice = 1'b1;
        end else if ((sc_cmd_valid || sc_reserve) &&
                     !(pf_cmd_valid && (streak_q == StreakMax))) begin
            choice = 1'b1;
        end
    end

    // Ownership is frozen for the whole transaction.
    assign sc_owner    = tx_active ? owner_q : choice;
    assign owner_valid = sc_owner ? sc_cmd_valid : pf_cmd_valid;

    assign full             = (count_q == CntW'(MAX_OUTSTANDING));
    assign empty            = (count_q == '0);
    assign outstanding      = count_q;
    assign tx_command_valid = owner_valid && !full;
    assign tx_command       = sc_owner ? sc_cmd : pf_cmd;
    assign tx_data          = sc_owner ? sc_data : pf_data;
    assign pf_tx_ev         = sc_owner ? 3'b000 : tx_ev;
    assign sc_tx_ev         = sc_owner ? tx_ev : 3'b000;

    assign head     = fifo_q[rd_q];
    assign pf_rx_ev = (!empty && !head) ? rx_ev : 5'b00000;
    assign sc_rx_ev = (!empty && head) ? rx_ev : 5'b00000;

    assign started = tx_ev[0];
    assign pop     = rx_ev[3] && !empty;
    // A push at full only lands if the same-cycle pop frees a slot.
    assign push    = started && (sc_owner ? sc_reply_wanted : 1'b1) && (!full || pop);

    always_comb begin
        streak_d = streak_q;
        if (!pf_cmd_valid) begin
            streak_d = '0;
        end else if (started && sc_owner) begin
            if (streak_q != StreakMax) streak_d = streak_q + 1'b1;
        end else if (started) begin
            streak_d = '0;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q   <= 1'b0;
            streak_q  <= '0;
            fifo_q    <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
            rx_orphan <= 1'b0;
        end else begin
            if (!tx_active) owner_q <= choice;
            streak_q <= streak_d;
            count_q  <= count_d;
            if (push) begin
                fifo_q[wr_q] <= sc_owner;
                wr_q         <= (wr_q == PtrLast) ? '0 : wr_q + 1'b1;
            end
            if (pop) rd_q <= (rd_q == PtrLast) ? '0 : rd_q + 1'b1;
            if (rx_ev[0] && empty) rx_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tx_channel_arbiter.sv
// Randomized and directed scoreboard bench for tx_channel_arbiter against a queue-based model.
module tb_tx_channel_arbiter;

    localparam int MAXO = 7;
    localparam int MAXS = 3;
    localparam int CW   = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pf_cmd_valid, sc_cmd_valid, sc_reply_wanted, sc_reserve, tx_active;
    logic [1:0]    pf_cmd, pf_data, sc_cmd, sc_data, tx_command, tx_data;
    logic          tx_command_valid, sc_owner, full, empty, rx_orphan;
    logic [2:0]    tx_ev, pf_tx_ev, sc_tx_ev;
    logic [4:0]    rx_ev, pf_rx_ev, sc_rx_ev;
    logic [CW-1:0] outstanding;

    tx_channel_arbiter #(
        .IO_BITS(2), .CMD_BITS(2), .MAX_OUTSTANDING(MAXO), .MAX_SC_STREAK(MAXS)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .pf_cmd_valid(pf_cmd_valid), .pf_cmd(pf_cmd), .pf_data(pf_data),
        .sc_cmd_valid(sc_cmd_valid), .sc_cmd(sc_cmd), .sc_data(sc_data),
        .sc_reply_wanted(sc_reply_wanted), .sc_reserve(sc_reserve),
        .tx_command_valid(tx_command_valid), .tx_command(tx_command), .tx_data(tx_data),
        .tx_ev(tx_ev), .tx_active(tx_active), .pf_tx_ev(pf_tx_ev), .sc_tx_ev(sc_tx_ev),
        .rx_ev(rx_ev), .pf_rx_ev(pf_rx_ev), .sc_rx_ev(sc_rx_ev),
        .sc_owner(sc_owner), .outstanding(outstanding), .full(full), .empty(empty),
        .rx_orphan(rx_orphan)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       owner;
        bit       valid;
        bit [1:0] cmd;
        bit [1:0] data;
        bit [2:0] pf_tx;
        bit [2:0] sc_tx;
        bit [4:0] pf_rx;
        bit [4:0] sc_rx;
        int       outst;
        bit       full;
        bit       empty;
        bit       orphan;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: registered view at the start of each cycle.
    bit m_owner_q;
    int m_streak;
    bit m_fifo[$];
    bit m_orphan;
    int act_left;
    bit start_log[$];

    function automatic void chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: one expectation per driven cycle, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sc_owner", sc_owner, e.owner);
                chk("tx_command_valid", tx_command_valid, e.valid);
                chk("tx_command", tx_command, e.cmd);
                chk("tx_data", tx_data, e.data);
                chk("pf_tx_ev", pf_tx_ev, e.pf_tx);
                chk("sc_tx_ev", sc_tx_ev, e.sc_tx);
                chk("pf_rx_ev", pf_rx_ev, e.pf_rx);
                chk("sc_rx_ev", sc_rx_ev, e.sc_rx);
                chk("outstanding", outstanding, e.outst);
                chk("full", full, e.full);
                chk("empty", empty, e.empty);
                chk("rx_orphan", rx_orphan, e.orphan);
            end
        end
    end

    task automatic model_reset();
        m_owner_q = 0;
        m_streak  = 0;
        m_fifo.delete();
        m_orphan  = 0;
        act_left  = 0;
    endtask

    task automatic drive_idle();
        pf_cmd_valid = 0; sc_cmd_valid = 0; sc_reply_wanted = 0; sc_reserve = 0;
        pf_cmd = 0; pf_data = 0; sc_cmd = 0; sc_data = 0;
        tx_ev = 0; tx_active = 0; rx_ev = 0;
    endtask

    // One clock of stimulus; the memory side starts a command when allowed (go) and valid,
    // or unconditionally when force_go is set and the channel is idle.
    task automatic do_cycle(input bit pfv, input bit scv, input bit res, input bit rw,
                            input bit rxd, input bit rxs, input bit go, input bit force_go);
        bit   act, choice, owner, ovalid, mfull, start, pop, want;
        int   size0;
        exp_t e;
        @(posedge clk);
        #1;
        act   = (act_left > 0);
        size0 = m_fifo.size();
        pf_cmd_valid = pfv; sc_cmd_valid = scv; sc_reserve = res; sc_reply_wanted = rw;
        pf_cmd = 2'($urandom); pf_data = 2'($urandom);
        sc_cmd = 2'($urandom); sc_data = 2'($urandom);
        rx_ev = {1'($urandom), rxd, 2'($urandom), rxs};
        tx_active = act;

        if (res) choice = 1;
        else if ((scv || res) && !(pfv && m_streak == MAXS)) choice = 1;
        else choice = 0;
        owner  = act ? m_owner_q : choice;
        ovalid = owner ? scv : pfv;
        mfull  = (size0 == MAXO);
        start  = !act && ((ovalid && !mfull && go) || force_go);
        tx_ev  = {1'($urandom), 1'($urandom), start};

        e.owner  = owner;
        e.valid  = ovalid && !mfull;
        e.cmd    = owner ? sc_cmd : pf_cmd;
        e.data   = owner ? sc_data : pf_data;
        e.pf_tx  = owner ? 3'b0 : tx_ev;
        e.sc_tx  = owner ? tx_ev : 3'b0;
        e.pf_rx  = (size0 > 0 && m_fifo[0] == 0) ? rx_ev : 5'b0;
        e.sc_rx  = (size0 > 0 && m_fifo[0] == 1) ? rx_ev : 5'b0;
        e.outst  = size0;
        e.full   = mfull;
        e.empty  = (size0 == 0);
        e.orphan = m_orphan;
        exp_q.push_back(e);

        if (start) begin
            #1;
            start_log.push_back(sc_owner);
        end

        if (!act) m_owner_q = choice;
        if (!pfv) m_streak = 0;
        else if (start && owner) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
        else if (start) m_streak = 0;
        pop = rxd && (size0 > 0);
        if (pop) void'(m_fifo.pop_front());
        want = start && (owner ? rw : 1'b1);
        if (want && (size0 < MAXO || pop)) m_fifo.push_back(owner);
        if (rxs && size0 == 0) m_orphan = 1;
        if (act) act_left--;
        if (start) act_left = $urandom_range(1, 3);
    endtask

    // Repeat a request until the channel starts it, bounded.
    task automatic issue(input bit pfv, input bit scv, input bit rw);
        int n0 = start_log.size();
        for (int i = 0; i < 20 && start_log.size() == n0; i++)
            do_cycle(pfv, scv, 0, rw, 0, 0, 1, 0);
        if (start_log.size() == n0) begin
            n_tests++; n_fail++;
            $display("FAIL issue_timeout: got no start expected one start");
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #1 drive_idle();
        #2 reset_n = 0;
        #1;
        chk("reset_orphan", rx_orphan, 0);
        chk("reset_outstanding", outstanding, 0);
        chk("reset_owner", sc_owner, 0);
        chk("reset_empty", empty, 1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        bit pat[8] = '{1, 1, 1, 0, 1, 1, 1, 0};
        int n;
        drive_idle();
        model_reset();
        reset_n = 0;
        @(negedge clk);
        @(negedge clk);
        chk("init_empty", empty, 1);
        chk("init_full", full, 0);
        chk("init_outstanding", outstanding, 0);
        chk("init_owner", sc_owner, 0);
        chk("init_valid", tx_command_valid, 0);
        chk("init_orphan", rx_orphan, 0);
        reset_n = 1;

        // PF only: three reads then three completions.
        for (int i = 0; i < 3; i++) issue(1, 0, 0);
        for (int i = 0; i < 6; i++) do_cycle(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, 0, 1, 0, 1, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 1, 0);

        // Streak fairness with both requesters always valid.
        async_reset();
        start_log.delete();
        for (int i = 0; i < 200 && start_log.size() < 8; i++)
            do_cycle(1, 1, 0, 0, 1, 0, 1, 0);
        n = start_log.size();
        chk("streak_starts", n, 8);
        for (int i = 0; i < 8; i++)
            if (i < n) chk($sformatf("streak_order_%0d", i), start_log[i], pat[i]);
        start_log.delete();
        for (int i = 0; i < 200 && start_log.size() < 4; i++)
            do_cycle(1, 1, 1, 0, 1, 0, 1, 0);
        chk("reserve_starts", start_log.size(), 4);
        foreach (start_log[i]) chk($sformatf("reserve_order_%0d", i), start_log[i], 1);

        // Ordering: PF read, SC read, SC write, PF read, then completions.
        async_reset();
        issue(1, 0, 0);
        issue(0, 1, 1);
        issue(0, 1, 0);
        issue(1, 0, 0);
        for (int i = 0; i < 4; i++) do_cycle(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, 0, 1, 1, 1, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 1, 0);

        // Full, drain one, refill, then push+pop at full.
        async_reset();
        for (int i = 0; i < MAXO; i++) issue(1, 0, 0);
        for (int i = 0; i < 5; i++) do_cycle(1, 0, 0, 0, 0, 0, 1, 0);
        do_cycle(1, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) do_cycle(1, 0, 0, 0, 0, 0, 1, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
        do_cycle(1, 0, 0, 0, 1, 0, 0, 1);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Orphan with empty FIFO.
        async_reset();
        do_cycle(0, 0, 0, 0, 1, 1, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic with a reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) async_reset();
            do_cycle($urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom_range(0, 9) == 0,
                     $urandom_range(0, 1), $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                     $urandom_range(0, 3) != 0, 0);
        end
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
